// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage of the rv32imc core.
//
// Issues loads and stores on the data memory port using a request/response
// handshake. Holds the pipeline while an access is outstanding, aligns and
// extends load data, and latches mem_stage_reg for writeback and forwarding.
//
// Ports:
//   clk           core clock
//   rst           asynchronous active-low reset
//   ex_stage_reg  execute-stage register (address, store data, controls)
//   mem_reg_we    global pipeline advance enable
//   o_stall       asks the hazard unit to freeze all pipeline enables
//   dmem_addr     word-aligned request address (request cycle only)
//   dmem_rmask    byte read enables (request cycle only)
//   dmem_wmask    byte write enables (request cycle only)
//   dmem_wdata    store data moved into its byte lanes (request cycle only)
//   dmem_rdata    read data, valid with dmem_resp
//   dmem_resp     single-cycle completion pulse
//   mem_stage_reg registered stage output

package mem_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_rdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic       regf_we;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic [31:0] pc_next;
        logic [31:0] alu_out;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } ex_stage_t;

    typedef struct packed {
        logic [31:0] pc_next;
        logic [31:0] alu_out;
        logic [31:0] mem_rdata;
        logic [4:0]  rd_addr;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } mem_stage_t;

endpackage

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access outstanding; issue a request or pass through
// BUSY  | request issued, waiting for dmem_resp
// DONE  | response captured in hold buffer, waiting for mem_reg_we
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ex_stage_t   ex_stage_reg,
    input  logic        mem_reg_we,
    output logic        o_stall,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output mem_stage_t  mem_stage_reg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] hold_q, hold_d;
    mem_stage_t  msr_q, msr_d;

    logic [31:0] addr;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic        mem_op;
    logic        misaligned;
    logic        issue;
    logic        req_out;
    logic [3:0]  acc_mask;
    logic [3:0]  rmask_iss;
    logic [3:0]  wmask_iss;
    logic [31:0] wdata_shift;
    logic [31:0] raw_sel;
    mem_stage_t  base;
    mem_stage_t  fin;

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  o,
                                                input logic [2:0]  fn3);
        logic [31:0] sh;
        sh = raw >> {o, 3'b000};
        case (fn3)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_extend = {24'h0, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_extend = {16'h0, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    assign addr   = ex_stage_reg.alu_out;
    assign off    = addr[1:0];
    assign f3     = ex_stage_reg.mem_ctrl.funct3;
    assign mem_op = ex_stage_reg.rvfi.valid &
                    (ex_stage_reg.mem_ctrl.mem_read | ex_stage_reg.mem_ctrl.mem_write);

    assign misaligned = ((f3[1:0] == 2'b01) & addr[0]) |
                        ((f3 == 3'b010) & (off != 2'b00));

    always_comb begin
        acc_mask = 4'b1111;
        case (f3[1:0])
            2'b00:   acc_mask = 4'b0001 << off;
            2'b01:   acc_mask = 4'b0011 << off;
            default: acc_mask = 4'b1111;
        endcase
    end

    assign rmask_iss   = ex_stage_reg.mem_ctrl.mem_read  ? acc_mask : 4'b0000;
    assign wmask_iss   = ex_stage_reg.mem_ctrl.mem_write ? acc_mask : 4'b0000;
    assign wdata_shift = ex_stage_reg.rs2_rdata << {off, 3'b000};

    assign issue   = (state_q == S_IDLE) & mem_op & ~misaligned;
    assign o_stall = issue | ((state_q == S_BUSY) & ~dmem_resp);

    // The stall equation stays live during reset, but the memory port is
    // forced quiet so no request can escape while the stage is held.
    assign req_out    = issue & rst;
    assign dmem_addr  = req_out ? {addr[31:2], 2'b00} : 32'h0;
    assign dmem_rmask = req_out ? rmask_iss : 4'b0000;
    assign dmem_wmask = req_out ? wmask_iss : 4'b0000;
    assign dmem_wdata = req_out ? wdata_shift : 32'h0;

    assign raw_sel = (state_q == S_DONE) ? hold_q : dmem_rdata;

    // Pass-through view of the instruction; a misaligned access becomes a
    // no-op by dropping its register write.
    always_comb begin
        base                = '0;
        base.pc_next        = ex_stage_reg.pc_next;
        base.alu_out        = ex_stage_reg.alu_out;
        base.rd_addr        = ex_stage_reg.rd_addr;
        base.wb_ctrl        = ex_stage_reg.wb_ctrl;
        base.rvfi           = ex_stage_reg.rvfi;
        base.rvfi.mem_addr  = addr;
        base.rvfi.mem_rmask = 4'b0000;
        base.rvfi.mem_wmask = 4'b0000;
        base.rvfi.mem_rdata = 32'h0;
        base.rvfi.mem_wdata = 32'h0;
        base.mem_rdata      = 32'h0;
        if (mem_op & misaligned) begin
            base.wb_ctrl.regf_we = 1'b0;
        end
    end

    // Completed-access view; ex_stage_reg is frozen while the access is in
    // flight, so the issued masks and store data can be recomputed here.
    always_comb begin
        fin                = base;
        fin.rvfi.mem_rmask = rmask_iss;
        fin.rvfi.mem_wmask = wmask_iss;
        fin.rvfi.mem_wdata = ex_stage_reg.mem_ctrl.mem_write ? wdata_shift : 32'h0;
        fin.rvfi.mem_rdata = raw_sel;
        fin.mem_rdata      = ex_stage_reg.mem_ctrl.mem_read ?
                             load_extend(raw_sel, off, f3) : 32'h0;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        msr_d   = msr_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_BUSY;
                end else if (mem_reg_we) begin
                    msr_d = base;
                end
            end
            S_BUSY: begin
                if (dmem_resp) begin
                    if (mem_reg_we) begin
                        msr_d   = fin;
                        state_d = S_IDLE;
                    end else begin
                        hold_d  = dmem_rdata;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (mem_reg_we) begin
                    msr_d   = fin;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hold_q  <= 32'h0;
            msr_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            msr_q   <= msr_d;
        end
    end

    assign mem_stage_reg = msr_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    ex_stage_t   ex_stage_reg;
    logic        mem_reg_we;
    logic        o_stall;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    mem_stage_t  mem_stage_reg;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ex_stage_reg (ex_stage_reg),
        .mem_reg_we   (mem_reg_we),
        .o_stall      (o_stall),
        .dmem_addr    (dmem_addr),
        .dmem_rmask   (dmem_rmask),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_stage_reg(mem_stage_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic        regf;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          lat;
        logic [3:0]  e_rmask;
        logic [3:0]  e_wmask;
        logic [31:0] e_daddr;
        logic [31:0] e_wdata;
        int          e_stall;
        logic [31:0] e_mrdata;
        logic        e_regf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_ex(input logic valid, input logic rd, input logic wr, input logic regf,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] pc);
        ex_stage_reg                    = '0;
        ex_stage_reg.pc_next            = pc;
        ex_stage_reg.alu_out            = addr;
        ex_stage_reg.rs2_rdata          = rs2;
        ex_stage_reg.rd_addr            = 5'd7;
        ex_stage_reg.mem_ctrl.mem_read  = rd;
        ex_stage_reg.mem_ctrl.mem_write = wr;
        ex_stage_reg.mem_ctrl.funct3    = f3;
        ex_stage_reg.wb_ctrl.regf_we    = regf;
        ex_stage_reg.wb_ctrl.wb_sel     = 2'b01;
        ex_stage_reg.rvfi.valid         = valid;
        ex_stage_reg.rvfi.pc_rdata      = pc - 32'd4;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int stalls;
        logic [31:0] pc;
        pc = 32'h1000 + 32'(i) * 4;
        @(negedge clk);
        set_ex(v.valid, v.rd, v.wr, v.regf, v.f3, v.addr, v.rs2, pc);
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk($sformatf("v%0d req rmask", i), 32'(dmem_rmask), 32'(v.e_rmask));
        chk($sformatf("v%0d req wmask", i), 32'(dmem_wmask), 32'(v.e_wmask));
        chk($sformatf("v%0d req addr", i), dmem_addr, v.e_daddr);
        chk($sformatf("v%0d req wdata", i), dmem_wdata, v.e_wdata);
        stalls = o_stall ? 1 : 0;
        mem_reg_we = !o_stall;
        for (int k = 0; k < v.lat; k++) begin
            @(negedge clk);
            dmem_resp  = (k == v.lat - 1);
            dmem_rdata = dmem_resp ? v.rdata : 32'h0;
            #1;
            if (o_stall) stalls++;
            chk($sformatf("v%0d busy masks", i), 32'({dmem_rmask, dmem_wmask}), 32'h0);
            mem_reg_we = !o_stall;
        end
        @(posedge clk);
        #1;
        dmem_resp  = 1'b0;
        mem_reg_we = 1'b0;
        chk($sformatf("v%0d stall cycles", i), 32'(stalls), 32'(v.e_stall));
        chk($sformatf("v%0d pc_next", i), mem_stage_reg.pc_next, pc);
        chk($sformatf("v%0d alu_out", i), mem_stage_reg.alu_out, v.addr);
        chk($sformatf("v%0d mem_rdata", i), mem_stage_reg.mem_rdata, v.e_mrdata);
        chk($sformatf("v%0d regf_we", i), 32'(mem_stage_reg.wb_ctrl.regf_we), 32'(v.e_regf));
        chk($sformatf("v%0d rvfi rmask", i), 32'(mem_stage_reg.rvfi.mem_rmask), 32'(v.e_rmask));
        chk($sformatf("v%0d rvfi wmask", i), 32'(mem_stage_reg.rvfi.mem_wmask), 32'(v.e_wmask));
        chk($sformatf("v%0d rvfi wdata", i), mem_stage_reg.rvfi.mem_wdata, v.e_wdata);
        chk($sformatf("v%0d rvfi rdata", i), mem_stage_reg.rvfi.mem_rdata,
            (v.lat > 0) ? v.rdata : 32'h0);
        chk($sformatf("v%0d rvfi addr", i), mem_stage_reg.rvfi.mem_addr, v.addr);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int stalls;
        //        valid rd wr regf f3     addr          rs2           rdata         lat rmask wmask daddr        wdata         stall mrdata       regf
        vecs[0]  = '{1, 1, 0, 1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 4'hF, 4'h0, 32'h100, 32'h0,        1, 32'hDEADBEEF, 1};
        vecs[1]  = '{1, 1, 0, 1, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 4'h8, 4'h0, 32'h100, 32'h0,        1, 32'hFFFFFF80, 1};
        vecs[2]  = '{1, 1, 0, 1, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 1, 4'h8, 4'h0, 32'h100, 32'h0,        1, 32'h00000080, 1};
        vecs[3]  = '{1, 0, 1, 0, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        2, 4'h0, 4'hC, 32'h200, 32'hABCD0000, 2, 32'h0,        0};
        vecs[4]  = '{1, 1, 0, 1, 3'b001, 32'h102, 32'h0,        32'h80017777, 1, 4'hC, 4'h0, 32'h100, 32'h0,        1, 32'hFFFF8001, 1};
        vecs[5]  = '{1, 1, 0, 1, 3'b101, 32'h100, 32'h0,        32'h0000F00D, 3, 4'h3, 4'h0, 32'h100, 32'h0,        3, 32'h0000F00D, 1};
        vecs[6]  = '{1, 0, 1, 0, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1, 4'h0, 4'h2, 32'h300, 32'h0000A500, 1, 32'h0,        0};
        vecs[7]  = '{1, 0, 1, 0, 3'b010, 32'h400, 32'hCAFEBABE, 32'h0,        1, 4'h0, 4'hF, 32'h400, 32'hCAFEBABE, 1, 32'h0,        0};
        vecs[8]  = '{1, 0, 0, 1, 3'b000, 32'h55,  32'h77,       32'h0,        0, 4'h0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        1};
        vecs[9]  = '{1, 1, 0, 1, 3'b010, 32'h102, 32'h0,        32'h0,        0, 4'h0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0};
        vecs[10] = '{0, 1, 0, 1, 3'b010, 32'h104, 32'h0,        32'h0,        0, 4'h0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        1};

        rst        = 1'b0;
        mem_reg_we = 1'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        chk("reset stall", 32'(o_stall), 32'h0);
        chk("reset masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
        chk("reset pc_next", mem_stage_reg.pc_next, 32'h0);
        chk("reset rvfi valid", 32'(mem_stage_reg.rvfi.valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Misaligned LH becomes a no-op; a following ADD advances without stall.
        @(negedge clk);
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h2000);
        #1;
        chk("mis stall", 32'(o_stall), 32'h0);
        chk("mis rmask", 32'(dmem_rmask), 32'h0);
        mem_reg_we = 1'b1;
        @(posedge clk);
        #1;
        chk("mis regf_we", 32'(mem_stage_reg.wb_ctrl.regf_we), 32'h0);
        chk("mis rvfi rmask", 32'(mem_stage_reg.rvfi.mem_rmask), 32'h0);
        chk("mis alu_out", mem_stage_reg.alu_out, 32'h101);
        @(negedge clk);
        set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h66, 32'h0, 32'h2004);
        #1;
        chk("add stall", 32'(o_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("add alu_out", mem_stage_reg.alu_out, 32'h66);
        chk("add regf_we", 32'(mem_stage_reg.wb_ctrl.regf_we), 32'h1);
        mem_reg_we = 1'b0;

        // LW with 3-cycle memory; pipeline stays frozen for 2 cycles after resp.
        @(negedge clk);
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'h3000);
        #1;
        chk("hold req rmask", 32'(dmem_rmask), 32'hF);
        stalls = o_stall ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dmem_resp  = (k == 2);
            dmem_rdata = (k == 2) ? 32'h13579BDF : 32'h0;
            #1;
            if (o_stall) stalls++;
            chk("hold busy rmask", 32'(dmem_rmask), 32'h0);
        end
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 32'hFFFFFFFF;
        #1;
        chk("done stall", 32'(o_stall), 32'h0);
        chk("done masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
        chk("done no latch", mem_stage_reg.alu_out, 32'h66);
        @(negedge clk);
        mem_reg_we = 1'b1;
        #1;
        chk("done no 2nd req", 32'(dmem_rmask), 32'h0);
        @(posedge clk);
        #1;
        mem_reg_we = 1'b0;
        chk("hold stall cycles", 32'(stalls), 32'd3);
        chk("hold mem_rdata", mem_stage_reg.mem_rdata, 32'h13579BDF);
        chk("hold rvfi rdata", mem_stage_reg.rvfi.mem_rdata, 32'h13579BDF);
        chk("hold pc_next", mem_stage_reg.pc_next, 32'h3000);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

        // Reset while BUSY; a late response after release must be ignored.
        @(negedge clk);
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h180, 32'h0, 32'h4000);
        #1;
        chk("rb req stall", 32'(o_stall), 32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rb busy stall", 32'(o_stall), 32'h1);
        rst = 1'b0;
        #1;
        chk("rb rst masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
        chk("rb rst addr", dmem_addr, 32'h0);
        chk("rb rst stall eq", 32'(o_stall), 32'h1);
        chk("rb rst pc_next", mem_stage_reg.pc_next, 32'h0);
        chk("rb rst mem_rdata", mem_stage_reg.mem_rdata, 32'h0);
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        chk("rb rst stall idle", 32'(o_stall), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h5555AAAA;
        #1;
        chk("rb late stall", 32'(o_stall), 32'h0);
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        chk("rb late mem_rdata", mem_stage_reg.mem_rdata, 32'h0);
        chk("rb late rvfi rdata", mem_stage_reg.rvfi.mem_rdata, 32'h0);
        @(negedge clk);
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 32'h5000);
        #1;
        chk("rb idle req rmask", 32'(dmem_rmask), 32'hF);
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h0000600D;
        #1;
        mem_reg_we = !o_stall;
        @(posedge clk);
        #1;
        dmem_resp  = 1'b0;
        mem_reg_we = 1'b0;
        chk("rb after mem_rdata", mem_stage_reg.mem_rdata, 32'h0000600D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the rv32imc core, sitting directly downstream of the execute stage. It consumes the latched execute-stage register and issues loads and stores to the data memory port with a request/response handshake. It stalls the pipeline while an access is outstanding, and aligns and sign- or zero-extends load data. It latches the `mem_stage_reg` consumed by writeback and by the execute-stage forwarding unit.

## Interface
Parameters: none.

Reset: one clock; reset is asynchronous and active-low.

Ports, as name, direction, width, meaning:

- `clk` — in, 1. Core clock.
- `rst` — in, 1. Asynchronous, active-low reset.
- `ex_stage_reg` — in, `ex_stage_t`. Execute-stage register.
  - Uses `alu_out` (effective address), `rs2_rdata` (store data), `rd_addr`, `pc_next`, `wb_ctrl`, `rvfi`.
  - Uses `mem_ctrl.mem_read`, `mem_ctrl.mem_write`, `mem_ctrl.funct3`.
- `mem_reg_we` — in, 1. Global pipeline advance enable, shared with `ex_reg_we`.
- `o_stall` — out, 1. Requests that the hazard unit deassert all pipeline enables.
- `dmem_addr` — out, 32. Word-aligned address, `{alu_out[31:2], 2'b00}`.
- `dmem_rmask` — out, 4. Byte read enables; nonzero for exactly the request cycle.
- `dmem_wmask` — out, 4. Byte write enables; nonzero for exactly the request cycle.
- `dmem_wdata` — out, 32. Store data shifted into byte lanes.
- `dmem_rdata` — in, 32. Read data; valid when `dmem_resp` = 1.
- `dmem_resp` — in, 1. Single-cycle completion pulse.
- `mem_stage_reg` — out, `mem_stage_t`. Fields: `pc_next`, `alu_out`, `mem_rdata`, `rd_addr`, `wb_ctrl`, `rvfi`.

## Operation
Definitions:
- `addr = ex_stage_reg.alu_out`, `off = addr[1:0]`, `f3 = mem_ctrl.funct3`.
- `mem_op = rvfi.valid & (mem_read | mem_write)`.
- `misaligned`: halfword (`f3[1:0]` = 01) with `addr[0]` = 1, or word (`f3` = 010) with `off` ≠ 0.

Masks:
- Byte: `4'b0001 << off`.
- Half: `4'b0011 << off`.
- Word: `4'b1111`.

Store data: `dmem_wdata = rs2_rdata << (8*off)`. All bits outside the mask are don't-care, but driven deterministically.

Load data:
- `sh = dmem_rdata >> (8*off)`.
- LB sign-extends `sh[7:0]`; LBU zero-extends `sh[7:0]`.
- LH sign-extends `sh[15:0]`; LHU zero-extends `sh[15:0]`.
- LW passes `sh` unchanged.

Misaligned access:
- No request is issued and no stall is raised.
- `wb_ctrl.regf_we` is forced to 0; rvfi masks are 0.
- The instruction passes through as a no-op.

FSM states: IDLE, BUSY, DONE.

- **IDLE**
  - If `mem_op` and not misaligned: drive the masks for one cycle and go to BUSY.
  - Otherwise act as a pass-through: latch on `mem_reg_we`.
  - `dmem_resp` is ignored in IDLE.
- **BUSY**
  - Masks are 0.
  - On `dmem_resp` with `mem_reg_we` = 1: latch `mem_stage_reg` using live `dmem_rdata`, go to IDLE.
  - On `dmem_resp` with `mem_reg_we` = 0: capture `dmem_rdata` into the hold buffer, go to DONE.
- **DONE**
  - On `mem_reg_we` = 1: latch from the hold buffer, go to IDLE.

`o_stall` (combinational) = `(IDLE & mem_op & ~misaligned) | (BUSY & ~dmem_resp)`.

Latch on `mem_reg_we` with no stall:
- `mem_stage_reg` receives `pc_next`, `alu_out`, `rd_addr`, `wb_ctrl` and `rvfi` copied from `ex_stage_reg`.
- `mem_rdata` = the extended load value, or 0 for a non-load.
- `rvfi.mem_addr` = `addr`.
- `rvfi.mem_rmask` / `rvfi.mem_wmask` = the issued masks.
- `rvfi.mem_wdata` = `dmem_wdata`.
- `rvfi.mem_rdata` = the raw `dmem_rdata` or hold-buffer value.

When `mem_reg_we` = 0 and there is no completion, `mem_stage_reg` holds.

## Timing
Reset (`rst` = 0, asynchronous):
- State = IDLE, hold buffer = 0, all `mem_stage_reg` fields = 0.
- `dmem_*` outputs are 0.
- `o_stall` then follows its equation with state = IDLE.

Reset mid-access: the stage returns to IDLE, and a `dmem_resp` arriving after reset is ignored.

Latency:
- Request on cycle 0 with `dmem_resp` on cycle 1: `o_stall` = 1 on cycle 0 only, and `mem_stage_reg` updates at the cycle-1 edge.
- Each additional memory wait cycle adds one stall cycle.
- Non-memory instructions have 0 stall cycles.

Handshake rules:
- At most one outstanding request.
- The address and masks are valid only in the request cycle.
- The memory must sample on that cycle.
- `dmem_resp` for a store carries don't-care `rdata`.

`ex_stage_reg` changes only on `mem_reg_we`, so the IDLE re-evaluation after completion always sees the next instruction.

## Test plan
- **LW, 1-cycle memory:** `addr` = 0x100, memory returns 0xDEADBEEF → `rmask` = 1111 for one cycle, 1 stall cycle, `mem_rdata` = 0xDEADBEEF.
- **LB / LBU at `off` = 3:** `rdata` = 0x80FF_0000 → LB `mem_rdata` = 0xFFFFFF80, LBU = 0x00000080, `rmask` = 1000.
- **SH at `addr` = 0x202:** `rs2` = 0x1234ABCD → `wmask` = 1100, `wdata[31:16]` = 0xABCD, `dmem_addr` = 0x200.
- **LW, 3-cycle response with `mem_reg_we` held low until 2 cycles after `dmem_resp`:** `o_stall` high for 3 cycles, DONE holds the data, latched value is correct, and no second request is issued.
- **LH at `addr` = 0x101:** no request, `o_stall` = 0, `regf_we` = 0; an ADD that follows latches with no stall.
- **`rst` asserted while in BUSY, then `dmem_resp` pulses after release:** all outputs are 0, the state is IDLE, and the late response is ignored.
